// File: rtl/instr_pkg.sv
// instr_pkg: shared definitions for the 16-bit instruction encoder.
//   - Bit positions of every field inside the packed instruction word.
//   - OPC_STORE, the register-format opcode with the alternate field layout.
//   - FSM state encoding used by instr_encoder (also seen on its debug port).
//   - instr_fields_t, the unpacked set of fields presented by the loader.
package instr_pkg;

  // Common header fields
  localparam int CC_HI  = 15;
  localparam int CC_LO  = 14;
  localparam int OP_HI  = 13;
  localparam int OP_LO  = 10;
  // Register / load format body
  localparam int DST_HI = 9;
  localparam int DST_LO = 7;
  localparam int OP1_HI = 6;
  localparam int OP1_LO = 4;
  localparam int OP2_HI = 3;
  localparam int OP2_LO = 1;
  localparam int LD_HI  = 6;
  localparam int LD_LO  = 0;
  // Store format moves operand2 into the slot normally holding dest_reg
  localparam int ST_OP2_HI = 9;
  localparam int ST_OP2_LO = 7;
  localparam int ST_PAD_HI = 3;
  localparam int ST_PAD_LO = 0;

  localparam logic [3:0] OPC_STORE = 4'b1110;

  // FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic       use_load;
    logic [1:0] cond_code;
    logic [3:0] opcode;
    logic [2:0] dest_reg;
    logic [2:0] operand1;
    logic [2:0] operand2;
    logic [6:0] load_bits;
  } instr_fields_t;

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: bundles every non-clock/reset signal of instr_encoder.
//   Loader side : start, base_addr, in_valid/in_ready/in_last, field inputs.
//   Memory side : mem_req/mem_gnt, mem_addr, mem_wdata.
//   Status      : busy, done, words_written, wrap_err.
// Modports:
//   master - the environment (loader + instruction memory) driving the encoder.
//   slave  - the encoder itself.
//
// Handshakes: a field transfer happens on a clk edge where in_valid && in_ready;
// a memory write happens on an edge where mem_req && mem_gnt. mem_req/mem_addr/
// mem_wdata are held stable until granted; mem_gnt without mem_req is ignored.
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic                  use_load;
  logic [1:0]            cond_code;
  logic [3:0]            opcode;
  logic [2:0]            dest_reg;
  logic [2:0]            operand1;
  logic [2:0]            operand2;
  logic [6:0]            load_bits;
  logic                  mem_req;
  logic                  mem_gnt;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH:0]   words_written;
  logic                  wrap_err;

  modport master (
    output start, base_addr, in_valid, in_last, use_load, cond_code, opcode,
           dest_reg, operand1, operand2, load_bits, mem_gnt,
    input  in_ready, mem_req, mem_addr, mem_wdata, busy, done, words_written,
           wrap_err
  );

  modport slave (
    input  start, base_addr, in_valid, in_last, use_load, cond_code, opcode,
           dest_reg, operand1, operand2, load_bits, mem_gnt,
    output in_ready, mem_req, mem_addr, mem_wdata, busy, done, words_written,
           wrap_err
  );
endinterface

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous FIFO holding packed instruction words.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset (empties the FIFO)
//   push, wdata - write wdata when push && !full
//   pop, rdata  - rdata is the head; pop advances it when !empty
//   full, empty - occupancy flags derived from count
//   count       - number of stored words (0..DEPTH)
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs per-field instruction requests into 16-bit words,
// buffers them and writes them to instruction memory from a base address.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset (abandons any load)
//   bus        - instr_encoder_if.slave: start/base_addr, field handshake,
//                memory write port and status outputs
//   dbg_state  - current FSM state (ST_IDLE/RUN/DRAIN/DONE)
module instr_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  instr_encoder_if.slave  bus,
  output logic [1:0]      dbg_state
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic                  wrap_q, wrap_d;

  instr_fields_t         fields;
  logic [15:0]           packed_word;
  logic [15:0]           fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  in_ready;
  logic                  push;
  logic                  mem_req;
  logic                  pop;
  logic                  active;

  assign fields = '{use_load:  bus.use_load,
                    cond_code: bus.cond_code,
                    opcode:    bus.opcode,
                    dest_reg:  bus.dest_reg,
                    operand1:  bus.operand1,
                    operand2:  bus.operand2,
                    load_bits: bus.load_bits};

  // Field packing. Store opcode in register format relocates operand2 into the
  // destination slot, since stores have no destination register.
  always_comb begin
    packed_word = '0;
    packed_word[CC_HI:CC_LO] = fields.cond_code;
    packed_word[OP_HI:OP_LO] = fields.opcode;
    if (fields.use_load) begin
      packed_word[DST_HI:DST_LO] = fields.dest_reg;
      packed_word[LD_HI:LD_LO]   = fields.load_bits;
    end else if (fields.opcode == OPC_STORE) begin
      packed_word[ST_OP2_HI:ST_OP2_LO] = fields.operand2;
      packed_word[OP1_HI:OP1_LO]       = fields.operand1;
      packed_word[ST_PAD_HI:ST_PAD_LO] = '0;
    end else begin
      packed_word[DST_HI:DST_LO] = fields.dest_reg;
      packed_word[OP1_HI:OP1_LO] = fields.operand1;
      packed_word[OP2_HI:OP2_LO] = fields.operand2;
    end
  end

  // in_ready looks only at the current occupancy, so a full FIFO refuses a
  // push even in a cycle where the head is being written out.
  assign active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign in_ready = (state_q == ST_RUN) && !fifo_full;
  assign push     = bus.in_valid && in_ready;
  assign mem_req  = active && !fifo_empty;
  assign pop      = mem_req && bus.mem_gnt;

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (packed_word),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    words_d = words_q;
    wrap_d  = wrap_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          addr_d  = bus.base_addr;
          words_d = '0;
          wrap_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (push && bus.in_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // An empty FIFO means mem_req is low, so nothing is outstanding.
        if (fifo_count == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Writes only complete in RUN/DRAIN, so this never collides with the
    // IDLE start-time initialisation above.
    if (pop) begin
      addr_d  = addr_q + ADDR_WIDTH'(1);
      words_d = words_q + (ADDR_WIDTH + 1)'(1);
      if (&addr_q) begin
        wrap_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      words_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.mem_req       = mem_req;
  assign bus.mem_addr      = addr_q;
  // Masked so the data bus reads zero whenever no write is requested.
  assign bus.mem_wdata     = mem_req ? fifo_head : 16'h0000;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.done          = (state_q == ST_DONE);
  assign bus.words_written = words_q;
  assign bus.wrap_err      = wrap_q;
  assign dbg_state         = state_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Instruction packer and program writer: the encode side of the 16-bit instruction format.
- Accepts per-field instruction requests over a valid/ready handshake and packs each into a 16-bit word.
- Buffers packed words in a small FIFO and writes them sequentially into instruction memory over a req/gnt port, starting at a programmable base address.
- Sits between the test/boot loader and instruction memory; its output words are exactly what the decode stage consumes.

Parameters:
- ADDR_WIDTH, 8, instruction memory address width.
- FIFO_DEPTH, 4, packed-word buffer depth; power of two, ≥2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a program load; sampled in IDLE only
- base_addr  in  ADDR_WIDTH  first write address, latched on start
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder accepts fields this cycle
- in_last  in  1  qualifies the final instruction of the program
- use_load  in  1  1 = load format, 0 = register format
- cond_code  in  2  condition code field
- opcode  in  4  opcode field
- dest_reg  in  3  destination register
- operand1  in  3  source operand 1
- operand2  in  3  source operand 2
- load_bits  in  7  immediate for load format
- mem_req  out  1  write request
- mem_gnt  in  1  memory accepts the write this cycle
- mem_addr  out  ADDR_WIDTH  write address
- mem_wdata  out  16  packed instruction
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when the load completes
- words_written  out  ADDR_WIDTH+1  writes completed since the last start
- wrap_err  out  1  sticky; address counter wrapped during this load

Behaviour:
- Reset:
  - Synchronous, active-low, on the clk edge.
  - All outputs go to 0; state = IDLE; FIFO is emptied.
  - Reset mid-load abandons the load: no further mem_req, no done pulse.
- Packing (combinational at push; the FIFO stores the packed word):
  - [15:14] = cond_code; [13:10] = opcode.
  - use_load=1: [9:7] = dest_reg, [6:0] = load_bits.
  - use_load=0, opcode=4'b1110: [9:7] = operand2, [6:4] = operand1, [3:0] = 0; dest_reg is ignored.
  - use_load=0, other opcodes: [9:7] = dest_reg, [6:4] = operand1, [3:1] = operand2, [0] = 0.
- FSM IDLE → RUN → DRAIN → DONE → IDLE:
  - IDLE: when start=1, latch base_addr into the address counter, clear words_written and wrap_err, go to RUN. A start seen in any other state is ignored.
  - RUN: in_ready = !fifo_full. A push occurs on in_valid && in_ready. A push with in_last=1 goes to DRAIN.
  - DRAIN: in_ready = 0. Once the FIFO is empty and no request is outstanding, go to DONE.
  - DONE: done = 1 for exactly one cycle, then IDLE.
- In IDLE and DONE, in_ready = 0.
- Push while full is never accepted, even when a pop happens in the same cycle: in_ready depends only on the current count.
- Memory write rules:
  - mem_req = !fifo_empty in RUN and DRAIN.
  - mem_wdata is the FIFO head; mem_addr is the counter value.
  - Both are held stable while mem_req=1 && mem_gnt=0.
  - A write completes on mem_req && mem_gnt: pop the FIFO, increment the address counter and words_written.
  - mem_gnt with mem_req=0 is ignored.
- Latency: a word accepted at edge N can drive mem_req from cycle N+1 at the earliest.
- Simultaneous push and pop: the count is unchanged, data order is preserved, and the head advances.
- Address wrap:
  - The counter wraps modulo 2^ADDR_WIDTH.
  - A write completing at address all-ones sets wrap_err, which stays set until the next start or reset.
  - Writing continues through the wrap.

Decomposition:
- Package instr_pkg holds:
  - field bit positions (CC_HI/LO, OP_HI/LO, DST_HI/LO, OP1_HI/LO, OP2_HI/LO, LD_HI/LO)
  - OPC_STORE = 4'b1110
  - FSM state encoding
- Sub-module instr_fifo: synchronous FIFO, 16-bit width, depth FIFO_DEPTH, with push, pop, full, empty and count.
- Packing and the FSM live in instr_encoder.

Test Plan:
- Register format: start with base_addr=8'h10; push cc=2'b01, op=4'b0011, dst=5, op1=2, op2=6, in_last=1; hold mem_gnt=1 → one write, addr 8'h10, wdata 16'h4EAC; done pulses once; words_written=1.
- Store and load formats: push op=4'b1110 with op1=3, op2=7, dst=1 → wdata 16'h3BB0. Then push use_load=1, cc=2'b00, op=4'b0001, dst=2, load_bits=7'h55 → wdata 16'h0555, at consecutive addresses.
- Backpressure: mem_gnt=0 while pushing 4 words → in_ready drops after 4 pushes; mem_addr/mem_wdata stay stable. Release mem_gnt → writes occur in order to base, base+1, base+2, base+3.
- Wrap: base_addr=8'hFE with 3 instructions → writes to FE, FF, 00; wrap_err=1; words_written=3.
- Reset mid-load: assert rst_n=0 after 2 of 4 writes → the next cycle has all outputs 0 and the FSM in IDLE. A new start with base_addr=8'h00 then works normally; words_written restarts from 0.
- Ignored events: start pulsed while in RUN → no change to address or count; mem_gnt pulsed in IDLE → no pop, no count change.
